vector_lane_unpack: RTL
=======================

// Module: vector_lane_unpack
// PURPOSE
//  Inverse of the vector lane-sum compute stage. Accepts one packed 64-bit word of 8 byte
//  lanes plus a 32-bit scalar. Recovers each lane's element field as (lane - scalar[7:0]) mod 256.
//  Writes the fields serially, one lane per cycle, into a 1024-bit vector register
//  (16 x 64-bit elements); the upper-half elements are the lane targets.
//  Presents the finished vector on a valid/ready output. Sits on the write-back path,
//  feeding the vector register file.
// PARAMETERS
//  LANES      8   packed lanes per input word; also the number of target elements
//  VEC_ELEMS  16  elements in the output vector
//  ELEM_W     64  element width, bits
//  FIELD_W    8   lane/field width, bits
//  FIELD_LSB  32  LSB of the field inside each element (field = elem[39:32])
// PORTS
//  clk        in   1     clock
//  rst        in   1     reset, asynchronous, active-high
//  in_valid   in   1     input word valid
//  in_ready   out  1     high only in IDLE
//  in_data    in   64    lane i at [63-8i -: 8]; lane 0 is the MSB byte
//  in_scalar  in   32    only [7:0] is used
//  out_valid  out  1     out_vec complete
//  out_ready  in   1     consumer accepts out_vec
//  out_vec    out  1024  element i at [1023-64i -: 64]
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  - Reset: rst is asynchronous and active-high.
//    - On reset: state=IDLE, lane_idx=0, out_valid=0, out_vec=0.
//    - in_ready=1 after release. busy=0.
//  - FSM IDLE -> UNPACK -> HOLD -> IDLE.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid && in_ready (edge E0): capture in_data and in_scalar[7:0].
//    - At E0: clear the vector register to 0 and set lane_idx=0; go to UNPACK.
//  - UNPACK:
//    - At each edge Ek (k=1..LANES), lane k-1 is written to element k-1, bits [FIELD_LSB +: FIELD_W].
//    - Written value = captured_lane[k-1] - captured_scalar_byte, 8-bit wraparound, no carry out.
//    - All other bits of the element remain 0.
//    - Elements LANES..VEC_ELEMS-1 (lower 512 bits) remain 0.
//  - Completion: at edge E(LANES), after writing the last lane, state=HOLD and out_valid=1.
//    Latency from accept to out_valid = LANES cycles (8).
//  - HOLD:
//    - out_vec stable while out_valid && !out_ready.
//    - On out_valid && out_ready: out_valid=0, state=IDLE; in_ready=1 on the next cycle.
//    - No same-cycle accept bypass.
//  - Inputs outside IDLE: in_valid is ignored. in_data and in_scalar are don't-care after capture.
//  - out_vec during UNPACK is the partially written vector; it is only valid when out_valid=1.
//  - Reset mid-operation: the word is abandoned with no partial output; all state returns to reset values.
//  - Throughput: one vector per LANES+2 cycles minimum (accept, 8 writes, handshake).
// CONFIGURATION
//  - Macro VLU_BASE_MERGE_EN.
//    - Defined: adds input port base_vec [1023:0]. At E0 the vector register loads base_vec
//      instead of 0, and only the field bits of elements 0..LANES-1 are overwritten.
//      All other bits pass through unchanged.
//    - Undefined: no base_vec port; all non-field bits are 0 as described above.
// STRUCTURE
//  - Package vector_lane_unpack_pkg:
//    - typedefs lane_t (FIELD_W), elem_t (ELEM_W), vec_t (VEC_ELEMS*ELEM_W).
//    - enum state_t {IDLE, UNPACK, HOLD}.
//    - localparam LANE_IDX_W = $clog2(LANES).
//  - Sub-module vlu_lane_sub: combinational (lane, scalar_byte) -> lane - scalar_byte, FIELD_W wide.
//    The top instantiates one vlu_lane_sub, muxed by lane_idx.
// TESTING
//  1. Basic unpack, lanes 0..7 recover 1..8.
//     - Stimulus: in_data=64'h1112_1314_1516_1718, in_scalar=32'h10.
//     - Response: out_valid 8 cycles after accept.
//     - Response: elements 0..7 = 64'h0000_0001_0000_0000 .. 64'h0000_0008_0000_0000;
//       out_vec[511:0]=0.
//  2. Wraparound.
//     - Stimulus: in_data=64'h0500_0000_0000_0000, in_scalar=32'hFFFF_FF10.
//     - Response: element 0 field=8'hF5.
//     - Response: elements 1..7 field=8'hF0; no other bits set.
//  3. Output backpressure.
//     - Stimulus: hold out_ready=0 for 20 cycles.
//     - Response: out_vec stable, in_ready=0, second in_valid ignored.
//     - Response: release -> one transfer, in_ready=1 next cycle.
//  4. Reset mid-operation.
//     - Stimulus: assert rst on the 4th UNPACK cycle.
//     - Response: immediately out_valid=0, out_vec=0, busy=0.
//     - Response: next word (test 1) unpacks correctly.
//  5. Back-to-back, out_ready=1.
//     - Stimulus: two words, the second held valid until accepted.
//     - Response: accepts are 10 cycles apart; both vectors correct and in order.
//  6. VLU_BASE_MERGE_EN.
//     - Stimulus: base_vec all 1s, test 1 stimulus.
//     - Response: elements 0..7 = 64'hFFFF_FF01_FFFF_FFFF .. 64'hFFFF_FF08_FFFF_FFFF.
//     - Response: out_vec[511:0] all 1s.

Source files
------------

// File: rtl/vector_lane_unpack_pkg.sv
// Shared types, sizes and index helpers for vector_lane_unpack.
package vector_lane_unpack_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned VEC_ELEMS  = 16;
  localparam int unsigned ELEM_W     = 64;
  localparam int unsigned FIELD_W    = 8;
  localparam int unsigned FIELD_LSB  = 32;
  localparam int unsigned SCALAR_W   = 32;
  localparam int unsigned IN_W       = LANES * FIELD_W;
  localparam int unsigned VEC_W      = VEC_ELEMS * ELEM_W;
  localparam int unsigned LANE_IDX_W = $clog2(LANES);

  typedef logic [FIELD_W-1:0] lane_t;
  typedef logic [ELEM_W-1:0]  elem_t;
  typedef logic [VEC_W-1:0]   vec_t;
  typedef logic [IN_W-1:0]    word_t;

  typedef enum logic [1:0] {IDLE, UNPACK, HOLD} state_t;

  // Lane 0 and element 0 sit at the MSB end of their buses.
  function automatic int unsigned lane_lsb(input int unsigned idx);
    return IN_W - FIELD_W * (idx + 1);
  endfunction

  function automatic int unsigned field_lsb(input int unsigned idx);
    return VEC_W - ELEM_W * (idx + 1) + FIELD_LSB;
  endfunction

endpackage

// File: rtl/vector_lane_unpack_if.sv
// Input word / output vector handshake bundle for vector_lane_unpack.
// VLU_BASE_MERGE_EN adds the base_vec input.
interface vector_lane_unpack_if;
  import vector_lane_unpack_pkg::*;

  logic                in_valid;
  logic                in_ready;
  word_t               in_data;
  logic [SCALAR_W-1:0] in_scalar;
  logic                out_valid;
  logic                out_ready;
  vec_t                out_vec;
  logic                busy;
`ifdef VLU_BASE_MERGE_EN
  vec_t                base_vec;

  modport master (output in_valid, in_data, in_scalar, out_ready, base_vec,
                  input  in_ready, out_valid, out_vec, busy);
  modport slave  (input  in_valid, in_data, in_scalar, out_ready, base_vec,
                  output in_ready, out_valid, out_vec, busy);
`else
  modport master (output in_valid, in_data, in_scalar, out_ready,
                  input  in_ready, out_valid, out_vec, busy);
  modport slave  (input  in_valid, in_data, in_scalar, out_ready,
                  output in_ready, out_valid, out_vec, busy);
`endif
endinterface

// File: rtl/vector_lane_unpack_lane_sub.sv
// Per-lane field recovery: lane minus scalar byte, modulo 2^FIELD_W.
module vlu_lane_sub
  import vector_lane_unpack_pkg::*;
(
  input  lane_t lane_i,
  input  lane_t scalar_i,
  output lane_t field_o
);

  assign field_o = lane_i - scalar_i;

endmodule

// File: rtl/vector_lane_unpack.sv
// Unpacks 8 byte lanes into the field bits of a 16x64-bit vector, one lane per cycle.
// Define VLU_BASE_MERGE_EN to seed the vector from base_vec instead of zero.
module vector_lane_unpack
  import vector_lane_unpack_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  vector_lane_unpack_if.slave  bus
);

  state_t                  state_q, state_d;
  logic [LANE_IDX_W-1:0]   lane_idx_q, lane_idx_d;
  word_t                   data_q, data_d;
  lane_t                   scalar_q, scalar_d;
  vec_t                    vec_q, vec_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;
  logic                    busy_q, busy_d;

  lane_t                   cur_lane;
  lane_t                   field;
  vec_t                    seed_vec;
  logic                    unused_scalar_hi;

`ifdef VLU_BASE_MERGE_EN
  assign seed_vec = bus.base_vec;
`else
  assign seed_vec = '0;
`endif

  assign unused_scalar_hi = ^bus.in_scalar[SCALAR_W-1:FIELD_W];

  assign cur_lane = data_q[lane_lsb(32'(lane_idx_q)) +: FIELD_W];

  vlu_lane_sub u_lane_sub (
    .lane_i   (cur_lane),
    .scalar_i (scalar_q),
    .field_o  (field)
  );

  always_comb begin
    state_d     = state_q;
    lane_idx_d  = lane_idx_q;
    data_d      = data_q;
    scalar_d    = scalar_q;
    vec_d       = vec_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          data_d     = bus.in_data;
          scalar_d   = bus.in_scalar[FIELD_W-1:0];
          vec_d      = seed_vec;
          lane_idx_d = '0;
          state_d    = UNPACK;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      UNPACK: begin
        vec_d[field_lsb(32'(lane_idx_q)) +: FIELD_W] = field;
        lane_idx_d = lane_idx_q + 1'b1;
        if (lane_idx_q == LANE_IDX_W'(LANES - 1)) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lane_idx_q  <= '0;
      data_q      <= '0;
      scalar_q    <= '0;
      vec_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_idx_q  <= lane_idx_d;
      data_q      <= data_d;
      scalar_q    <= scalar_d;
      vec_q       <= vec_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = vec_q;
  assign bus.busy      = busy_q;

endmodule
